// File: rtl/i2c_pkg.sv
// Constants, ASCII codes and state encodings shared by the temperature-sensor
// controller and its binary-to-ASCII converter.
package i2c_pkg;

  localparam logic [6:0] SENSOR_ADDR_DEF = 7'h48;
  localparam logic [7:0] TEMP_REG_DEF    = 8'h00;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_FIVE  = 8'h35;

  // "I2C ERR", first character in the most significant byte.
  localparam logic [55:0] ERR_STR = 56'h49_32_43_20_45_52_52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_B0,
    ST_WAIT_B1,
    ST_CONVERT,
    ST_WRITE,
    ST_DONE,
    ST_POLL
  } ctrl_state_e;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_HUND,
    CV_TENS
  } conv_phase_e;

  function automatic logic [7:0] err_char(input logic [2:0] k);
    return ERR_STR[8*(6-int'(k)) +: 8];
  endfunction

endpackage

// File: rtl/temp_bin_to_ascii.sv
// Converts a 9-bit two's-complement half-degree reading into ASCII sign,
// three integer digits and a fraction digit by repeated subtraction.
module temp_bin_to_ascii
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] t_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] sign_ch,
  output logic [7:0] hund_ch,
  output logic [7:0] tens_ch,
  output logic [7:0] units_ch,
  output logic [7:0] frac_ch
);

  conv_phase_e phase_q, phase_d;
  logic       neg_q, neg_d;
  logic       half_q, half_d;
  logic       hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [7:0] rem_q, rem_d;
  logic [8:0] mag;

  // -256 negates to 9'h100, so the magnitude always fits in 9 bits.
  assign mag = t_in[8] ? (~t_in + 9'd1) : t_in;

  always_comb begin
    phase_d = phase_q;
    neg_d   = neg_q;
    half_d  = half_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    rem_d   = rem_q;
    done    = 1'b0;
    case (phase_q)
      CV_IDLE: begin
        if (start) begin
          neg_d   = t_in[8];
          half_d  = mag[0];
          rem_d   = mag[8:1];
          hund_d  = 1'b0;
          tens_d  = 4'd0;
          phase_d = CV_HUND;
        end
      end
      CV_HUND: begin
        if (rem_q >= 8'd100) begin
          rem_d  = rem_q - 8'd100;
          hund_d = 1'b1;
        end
        phase_d = CV_TENS;
      end
      CV_TENS: begin
        if (rem_q >= 8'd10) begin
          rem_d  = rem_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          done    = 1'b1;
          phase_d = CV_IDLE;
        end
      end
      default: phase_d = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= CV_IDLE;
      neg_q   <= 1'b0;
      half_q  <= 1'b0;
      hund_q  <= 1'b0;
      tens_q  <= 4'd0;
      rem_q   <= 8'd0;
    end else begin
      phase_q <= phase_d;
      neg_q   <= neg_d;
      half_q  <= half_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      rem_q   <= rem_d;
    end
  end

  assign busy     = (phase_q != CV_IDLE);
  assign sign_ch  = neg_q ? ASCII_MINUS : ASCII_PLUS;
  assign hund_ch  = ASCII_ZERO + {7'd0, hund_q};
  assign tens_ch  = ASCII_ZERO + {4'd0, tens_q};
  assign units_ch = ASCII_ZERO + {4'd0, rem_q[3:0]};
  assign frac_ch  = half_q ? ASCII_FIVE : ASCII_ZERO;

endmodule

// File: rtl/i2c_master_tempsensor_controller.sv
// Polls an LM75-class sensor through the I2C master and writes the reading
// as a 7-character ASCII string into the LCD RAM write port.
module i2c_master_tempsensor_controller
  import i2c_pkg::*;
#(
  parameter logic [6:0] SENSOR_ADDR = SENSOR_ADDR_DEF,
  parameter logic [7:0] TEMP_REG    = TEMP_REG_DEF,
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         POLL_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Controller_Enable,
  input  logic       Master_Ready,
  input  logic       Master_Done,
  input  logic       Master_ACK,
  input  logic [7:0] Master_ReadData,
  output logic       Master_Go,
  output logic       Master_RW,
  output logic [5:0] Master_NumOfBytes,
  output logic [6:0] Master_SlaveAddr,
  output logic [7:0] Master_SlaveRegAddr,
  output logic [7:0] Master_DataWriteReg,
  output logic       Master_Stop,
  output logic [7:0] RAM_ADD,
  output logic [7:0] RAM_DIN,
  output logic       RAM_W,
  output logic       Controller_Done,
  output logic [3:0] dbg_state
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);

  ctrl_state_e   state_q, state_d;
  logic          go_q, go_d;
  logic [7:0]    msb_q, msb_d;
  logic          err_q, err_d;
  logic [2:0]    wr_idx_q, wr_idx_d;
  logic [PW-1:0] poll_q, poll_d;

  logic       conv_start, conv_busy, conv_done;
  logic [7:0] sign_ch, hund_ch, tens_ch, units_ch, frac_ch;
  logic [7:0] char_ch;
  logic       active;

  temp_bin_to_ascii u_conv (
    .clk      (clk),
    .reset    (reset),
    .start    (conv_start),
    .t_in     ({msb_q, Master_ReadData[7]}),
    .busy     (conv_busy),
    .done     (conv_done),
    .sign_ch  (sign_ch),
    .hund_ch  (hund_ch),
    .tens_ch  (tens_ch),
    .units_ch (units_ch),
    .frac_ch  (frac_ch)
  );

  always_comb begin
    char_ch = ASCII_C;
    case (wr_idx_q)
      3'd0:    char_ch = sign_ch;
      3'd1:    char_ch = hund_ch;
      3'd2:    char_ch = tens_ch;
      3'd3:    char_ch = units_ch;
      3'd4:    char_ch = ASCII_DOT;
      3'd5:    char_ch = frac_ch;
      default: char_ch = ASCII_C;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    go_d            = 1'b0;
    msb_d           = msb_q;
    err_d           = err_q;
    wr_idx_d        = wr_idx_q;
    poll_d          = poll_q;
    conv_start      = 1'b0;
    RAM_W           = 1'b0;
    RAM_ADD         = 8'd0;
    RAM_DIN         = 8'd0;
    Controller_Done = 1'b0;
    case (state_q)
      ST_IDLE: if (Controller_Enable) state_d = ST_ARM;
      ST_ARM: begin
        if (!Controller_Enable) begin
          state_d = ST_IDLE;
        end else if (Master_Ready) begin
          go_d    = 1'b1;
          state_d = ST_WAIT_B0;
        end
      end
      ST_WAIT_B0: begin
        if (Master_Done) begin
          msb_d   = Master_ReadData;
          err_d   = err_q | Master_ACK;
          state_d = ST_WAIT_B1;
        end
      end
      ST_WAIT_B1: begin
        // The converter samples the LSB straight off the bus in this cycle.
        if (Master_Done) begin
          err_d    = err_q | Master_ACK;
          wr_idx_d = 3'd0;
          if (err_q | Master_ACK) begin
            state_d = ST_WRITE;
          end else begin
            conv_start = 1'b1;
            state_d    = ST_CONVERT;
          end
        end
      end
      ST_CONVERT: if (conv_done) state_d = ST_WRITE;
      ST_WRITE: begin
        RAM_W   = 1'b1;
        RAM_ADD = BASE_ADDR + {5'd0, wr_idx_q};
        RAM_DIN = err_q ? err_char(wr_idx_q) : char_ch;
        if (wr_idx_q == 3'd6) state_d = ST_DONE;
        else wr_idx_d = wr_idx_q + 3'd1;
      end
      ST_DONE: begin
        Controller_Done = 1'b1;
        err_d           = 1'b0;
        if (Controller_Enable) begin
          poll_d  = POLL_LOAD;
          state_d = ST_POLL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POLL: begin
        if (!Controller_Enable) state_d = ST_IDLE;
        else if (poll_q == '0) state_d = ST_ARM;
        else poll_d = poll_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      go_q     <= 1'b0;
      msb_q    <= 8'd0;
      err_q    <= 1'b0;
      wr_idx_q <= 3'd0;
      poll_q   <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      msb_q    <= msb_d;
      err_q    <= err_d;
      wr_idx_q <= wr_idx_d;
      poll_q   <= poll_d;
    end
  end

  // Command fields are constant whenever a poll cycle is in progress.
  assign active              = (state_q != ST_IDLE);
  assign Master_Go           = go_q;
  assign Master_RW           = active;
  assign Master_NumOfBytes   = active ? 6'd2 : 6'd0;
  assign Master_SlaveAddr    = active ? SENSOR_ADDR : 7'd0;
  assign Master_SlaveRegAddr = active ? TEMP_REG : 8'd0;
  assign Master_DataWriteReg = 8'd0;
  assign Master_Stop         = active;
  assign dbg_state           = {conv_busy, state_q};

endmodule

// File: tb/tb_i2c_master_tempsensor_controller.sv
// Bench for the temperature-sensor controller: scripted I2C master responses,
// RAM writes scored against an expected-character queue.
module tb_i2c_master_tempsensor_controller;

  localparam int         POLL = 16;
  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Controller_Enable = 1'b0;
  logic       Master_Ready = 1'b1;
  logic       Master_Done = 1'b0;
  logic       Master_ACK = 1'b0;
  logic [7:0] Master_ReadData = 8'd0;
  logic       Master_Go, Master_RW, Master_Stop, RAM_W, Controller_Done;
  logic [5:0] Master_NumOfBytes;
  logic [6:0] Master_SlaveAddr;
  logic [7:0] Master_SlaveRegAddr, Master_DataWriteReg, RAM_ADD, RAM_DIN;
  logic [3:0] dbg_state;

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  int go_cyc = 0;
  int done_cyc = 0;

  i2c_master_tempsensor_controller #(.POLL_CYCLES(POLL)) dut (
    .clk                 (clk),
    .reset               (reset),
    .Controller_Enable   (Controller_Enable),
    .Master_Ready        (Master_Ready),
    .Master_Done         (Master_Done),
    .Master_ACK          (Master_ACK),
    .Master_ReadData     (Master_ReadData),
    .Master_Go           (Master_Go),
    .Master_RW           (Master_RW),
    .Master_NumOfBytes   (Master_NumOfBytes),
    .Master_SlaveAddr    (Master_SlaveAddr),
    .Master_SlaveRegAddr (Master_SlaveRegAddr),
    .Master_DataWriteReg (Master_DataWriteReg),
    .Master_Stop         (Master_Stop),
    .RAM_ADD             (RAM_ADD),
    .RAM_DIN             (RAM_DIN),
    .RAM_W               (RAM_W),
    .Controller_Done     (Controller_Done),
    .dbg_state           (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (RAM_W === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected: got addr=%h data=%h, expected none", RAM_ADD, RAM_DIN);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({RAM_ADD, RAM_DIN} !== e) begin
          errors++;
          $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                   RAM_ADD, RAM_DIN, e[15:8], e[7:0]);
        end
      end
    end
    if (Controller_Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (Master_Go === 1'b1) begin
      go_cnt++;
      go_cyc = cyc;
    end
  end

  function automatic logic [55:0] model_str(input logic [7:0] b0, input logic [7:0] b1);
    logic signed [8:0] t;
    int v, i;
    logic [7:0] s, f;
    t = {b0, b1[7]};
    v = int'(t);
    if (v < 0) begin s = 8'h2D; v = -v; end
    else s = 8'h2B;
    i = v / 2;
    f = (v % 2 != 0) ? 8'h35 : 8'h30;
    return {s, 8'h30 + 8'(i / 100), 8'h30 + 8'((i / 10) % 10), 8'h30 + 8'(i % 10), 8'h2E, f, 8'h43};
  endfunction

  task automatic push_str(input logic [55:0] s);
    for (int k = 0; k < 7; k++) exp_q.push_back({BASE + 8'(k), s[8*(6-k) +: 8]});
  endtask

  // Driver: wait for Master_Go, then return two bytes like the I2C master.
  task automatic start_xfer(input logic [7:0] b0, input logic [7:0] b1, input logic a0,
                            input logic a1, input int gap, input bit drop_en, output bit ok);
    bit seen;
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (Master_Go === 1'b1) seen = 1;
    end
    checks++;
    ok = seen;
    if (!seen) begin
      errors++;
      $display("FAIL go_timeout: got no Master_Go, expected one within 300 cycles");
      return;
    end
    checks++;
    if ({Master_RW, Master_NumOfBytes, Master_SlaveAddr, Master_SlaveRegAddr, Master_DataWriteReg, Master_Stop}
        !== {1'b1, 6'd2, 7'h48, 8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL cmd_fields: got rw=%b n=%0d sa=%h ra=%h wd=%h stop=%b, expected 1 2 48 00 00 1",
               Master_RW, Master_NumOfBytes, Master_SlaveAddr, Master_SlaveRegAddr,
               Master_DataWriteReg, Master_Stop);
    end
    @(posedge clk); #1;
    Master_Done = 1'b1; Master_ReadData = b0; Master_ACK = a0;
    @(posedge clk); #1;
    if (gap > 0) begin
      Master_Done = 1'b0; Master_ACK = 1'b0;
      if (drop_en) Controller_Enable = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    Master_Done = 1'b1; Master_ReadData = b1; Master_ACK = a1;
    @(posedge clk); #1;
    Master_Done = 1'b0; Master_ACK = 1'b0; Master_ReadData = 8'd0;
  endtask

  task automatic serve(input logic [7:0] b0, input logic [7:0] b1, input logic a0,
                       input logic a1, input int gap, input bit drop_en);
    bit ok, seen;
    int prev;
    prev = done_cnt;
    start_xfer(b0, b1, a0, a1, gap, drop_en, ok);
    if (!ok) begin exp_q.delete(); return; end
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (done_cnt != prev) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no Controller_Done, expected one within 100 cycles");
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== prev + 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d, expected %0d", done_cnt - prev, 1);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL chars_missing: got %0d left in queue, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({Master_Go, RAM_W, Controller_Done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got go=%b w=%b done=%b, expected 0 0 0", Master_Go, RAM_W, Controller_Done);
    end
    checks++;
    if ({Master_RW, Master_NumOfBytes, Master_SlaveAddr, Master_SlaveRegAddr, Master_Stop} !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got rw=%b n=%0d sa=%h ra=%h stop=%b, expected all 0",
               Master_RW, Master_NumOfBytes, Master_SlaveAddr, Master_SlaveRegAddr, Master_Stop);
    end
    checks++;
    if ({RAM_ADD, RAM_DIN, Master_DataWriteReg, dbg_state[2:0]} !== '0) begin
      errors++;
      $display("FAIL reset_ram_state: got add=%h din=%h state=%0d, expected 0 0 0", RAM_ADD, RAM_DIN, dbg_state[2:0]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_positive();
    Controller_Enable = 1'b1;
    push_str("+025.5C");
    serve(8'h19, 8'h80, 1'b0, 1'b0, 2, 1'b0);
  endtask

  task automatic test_negative();
    push_str("-000.5C");
    serve(8'hFF, 8'h80, 1'b0, 1'b0, 3, 1'b0);
    push_str("-025.0C");
    serve(8'hE7, 8'h00, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_extremes();
    push_str("-128.0C");
    serve(8'h80, 8'h00, 1'b0, 1'b0, 1, 1'b0);
    push_str("+125.0C");
    serve(8'h7D, 8'h00, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_nack();
    push_str("I2C ERR");
    serve(8'h19, 8'h80, 1'b1, 1'b0, 1, 1'b0);
    push_str("+050.0C");
    serve(8'h32, 8'h00, 1'b0, 1'b0, 1, 1'b0);
    push_str("I2C ERR");
    serve(8'h32, 8'h00, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b0, b1;
    for (int i = 0; i < 6; i++) begin
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      push_str(model_str(b0, b1));
      serve(b0, b1, 1'b0, 1'b0, $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_period();
    int d;
    push_str(model_str(8'h05, 8'h00));
    serve(8'h05, 8'h00, 1'b0, 1'b0, 1, 1'b0);
    d = done_cyc;
    push_str(model_str(8'hF0, 8'h80));
    serve(8'hF0, 8'h80, 1'b0, 1'b0, 1, 1'b0);
    checks++;
    if (go_cyc - d !== POLL + 2) begin
      errors++;
      $display("FAIL poll_period: got %0d cycles done-to-go, expected %0d", go_cyc - d, POLL + 2);
    end
  endtask

  task automatic test_enable_drop();
    int snap;
    push_str("+025.5C");
    serve(8'h19, 8'h80, 1'b0, 1'b0, 2, 1'b1);
    snap = go_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (go_cnt !== snap) begin
      errors++;
      $display("FAIL drop_no_go: got %0d extra Master_Go, expected 0", go_cnt - snap);
    end
    checks++;
    if (dbg_state[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL drop_idle: got state %0d, expected 0", dbg_state[2:0]);
    end
  endtask

  task automatic test_ready_stall();
    int snap;
    snap = go_cnt;
    @(posedge clk); #1;
    Master_Ready = 1'b0;
    Controller_Enable = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (go_cnt !== snap) begin
      errors++;
      $display("FAIL stall_no_go: got %0d Master_Go, expected 0", go_cnt - snap);
    end
    checks++;
    if (dbg_state[2:0] !== 3'd1) begin
      errors++;
      $display("FAIL stall_arm: got state %0d, expected 1", dbg_state[2:0]);
    end
    @(posedge clk); #1;
    Master_Ready = 1'b1;
    push_str("+125.0C");
    serve(8'h7D, 8'h00, 1'b0, 1'b0, 1, 1'b0);
    checks++;
    if (go_cnt !== snap + 1) begin
      errors++;
      $display("FAIL stall_one_go: got %0d Master_Go, expected 1", go_cnt - snap);
    end
  endtask

  task automatic test_reset_write();
    bit ok, seen;
    int prev;
    push_str(model_str(8'h19, 8'h80));
    start_xfer(8'h19, 8'h80, 1'b0, 1'b0, 1, 1'b0, ok);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (RAM_W === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL write_timeout: got no RAM_W, expected one within 50 cycles");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    Controller_Enable = 1'b0;
    prev = done_cnt;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({RAM_W, Controller_Done, Master_Go} !== 3'b000) begin
      errors++;
      $display("FAIL reset_in_write: got w=%b done=%b go=%b, expected 0 0 0", RAM_W, Controller_Done, Master_Go);
    end
    checks++;
    if (dbg_state[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_write_state: got %0d, expected 0", dbg_state[2:0]);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt !== prev) begin
      errors++;
      $display("FAIL reset_no_done: got %0d Controller_Done, expected 0", done_cnt - prev);
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_extremes();
    test_nack();
    test_random();
    test_period();
    test_enable_drop();
    test_ready_stall();
    test_reset_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_tempsensor_controller.md
# i2c_master_tempsensor_controller

Periodically reads an LM75-class temperature sensor through the I2C master and writes the result as 7 ASCII characters into the remote-RAM write port feeding the LCD menu. It is a sibling of the Spartan-slave controller. It is enabled by `enableControllers[1]` and shares the master-command and RAM-write buses with that controller.

## Interface
- `SENSOR_ADDR`, 7'h48: 7-bit I2C device address.
- `TEMP_REG`, 8'h00: sensor temperature pointer register.
- `BASE_ADDR`, 8'h10: RAM address of the first character.
- `POLL_CYCLES`, 50_000_000: clocks from one display update to the next read.
- `clk` input 1: system clock; one clock domain.
- `reset` input 1: synchronous, active-high.
- `Controller_Enable` input 1: level; high means polling runs.
- `Master_Ready` input 1: master idle and able to accept `Master_Go`.
- `Master_Done` input 1: one-cycle pulse per received byte; `Master_ReadData` is valid in that cycle.
- `Master_ACK` input 1: acknowledge-error flag, sampled with each `Master_Done`; 1 means the slave NACKed.
- `Master_ReadData` input 8: received byte.
- `Master_Go` output 1: one-cycle transaction start.
- `Master_RW` output 1: fixed at 1 (read) while the block is not idle.
- `Master_NumOfBytes` output 6: 6'd2.
- `Master_SlaveAddr` output 7: `SENSOR_ADDR`.
- `Master_SlaveRegAddr` output 8: `TEMP_REG`.
- `Master_DataWriteReg` output 8: 8'h00.
- `Master_Stop` output 1: 1 (STOP after the transfer).
- `RAM_ADD` output 8: character write address.
- `RAM_DIN` output 8: ASCII character.
- `RAM_W` output 1: write strobe, one character per cycle.
- `Controller_Done` output 1: one-cycle pulse after the 7th character is written.

## Operation
- **States:** IDLE → ARM → WAIT_B0 → WAIT_B1 → CONVERT → WRITE → DONE → POLL → ARM.
- **IDLE:** all command outputs are 0. Go to ARM when `Controller_Enable`=1.
- **ARM:** wait for `Master_Ready`=1. Pulse `Master_Go` for exactly one cycle, then go to WAIT_B0. Command fields are stable from ARM entry until WAIT_B1 exits.
- **WAIT_B0:** on `Master_Done`, latch byte 0 into MSB. WAIT_B1: on `Master_Done`, latch LSB[7].
- **ACK error:** if any `Master_ACK`=1 is sampled, set an error flag. The sequence still proceeds through WAIT_B1 and then skips to WRITE, which emits the ASCII string "I2C ERR".
- **CONVERT:** form the 9-bit two's-complement value T = {MSB, LSB[7]} in units of 0.5 °C.
  - Sign: '-' if T[8]=1, else '+'.
  - Magnitude M = |T| as 9 bits; −256 gives M=256.
  - Integer part I = M[8:1], range 0..128. Fraction digit is '5' if M[0]=1, else '0'.
  - BCD is produced by sequential subtraction: at most one subtract of 100, at most nine of 10; the remainder is the units digit.
- **WRITE:** 7 consecutive cycles of `RAM_W`=1. `RAM_ADD` = `BASE_ADDR`+k for k = 0..6. Characters are sign, hundreds, tens, units, '.', fraction, 'C'. Leading zeros are kept ("+025.5C").
- **DONE:** pulse `Controller_Done` for one cycle and clear the error flag.
- **POLL:** count `POLL_CYCLES`−1 down to 0, then go to ARM. If `Controller_Enable`=0 in POLL, go to IDLE immediately.
- **Enable dropped in ARM** before `Master_Go`: go to IDLE.
- **Enable dropped in WAIT_B0, WAIT_B1, CONVERT or WRITE:** no abort; finish through DONE, then go to IDLE. An I2C transfer is never left open.

## Timing
- **Reset values:** every output is 0, state is IDLE, poll counter is 0, error flag is 0. Reset in any state takes effect at the next edge and overrides every other event.
- **Go handshake:** `Master_Go` is registered, asserted in the cycle after `Master_Ready` is seen high in ARM.
- **Back-to-back bytes:** a `Master_Done` arriving in the cycle WAIT_B1 is entered is captured.
- **CONVERT latency:** at most 12 cycles. Error path: 0 cycles.
- **Cycle budget:** `Master_Done`(byte 1) to first `RAM_W` is at most 13 cycles. Last `RAM_W` to `Controller_Done` is 1 cycle.

## Structure
- **Shared package `i2c_pkg`:** sensor address and pointer constants, the ASCII constants ('+', '-', '.', 'C', '0'), the 7-byte error string, and the controller state encoding.
- **Sub-module `temp_bin_to_ascii`:**
  - Interface: start/busy/done handshake; 9-bit T in; sign, hundreds, tens, units and fraction ASCII out.
  - Owns the CONVERT subtraction loop.
  - The FSM, poll counter and RAM sequencing stay in the top block.

## Test plan
- **Positive half-degree:** bytes 8'h19, 8'h80 → RAM[0x10..0x16] = "+025.5C", one `Controller_Done` pulse.
- **Negative half-degree:** 8'hFF, 8'h80 → "-000.5C". 8'hE7, 8'h00 → "-025.0C".
- **Extremes:** 8'h80, 8'h00 → "-128.0C". 8'h7D, 8'h00 → "+125.0C".
- **NACK:** `Master_ACK`=1 with byte 0 → "I2C ERR". The next poll with good data writes a normal string.
- **Ready stall:** `Master_Ready` held low 20 cycles in ARM → no `Master_Go` until Ready rises, then exactly one pulse.
- **Enable/reset mid-operation:**
  - Enable dropped during WAIT_B1 → the string is still written, `Controller_Done` pulses, then the block sits in IDLE.
  - `reset` in WRITE → `RAM_W` is 0 on the next cycle.
  - `POLL_CYCLES`=16 → `Master_Go` pulses are spaced by the measured period.
